// File: rtl/sram_pkg.sv
// Shared types and helpers for the 32-bit-word to 16-bit asynchronous SRAM controller.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  // Active-low {ub_n, lb_n} lane strobes for one half of a 4-bit byte mask.
  function automatic logic [1:0] lanes_n(input logic [3:0] bmask, input logic hi);
    logic [1:0] pair;
    pair = hi ? bmask[3:2] : bmask[1:0];
    return ~pair;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Splits each 32-bit request into low/high 16-bit SRAM accesses with registered pins,
// byte-lane masking and a one-cycle completion acknowledge.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ACC_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req,
  input  logic               i_wren,
  input  logic [18:0]        i_addr,
  input  logic [3:0]         i_bmask,
  input  logic [31:0]        i_wdata,
  output logic               o_ready,
  output logic               o_ack,
  output logic [31:0]        o_rdata,
  output logic [SRAM_AW-1:0] o_sram_addr,
  inout  wire  [SRAM_DW-1:0] io_sram_dq,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n
);

  localparam int PW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(ACC_CYCLES - 1);
  localparam logic [PW-1:0] PH_ZERO = PW'(0);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);

  state_e               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 wren_q, wren_d;
  logic [16:0]          word_q, word_d;
  logic [3:0]           bmask_q, bmask_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          shadow_q, shadow_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 ack_q, ack_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic                 ce_n_q, ce_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic                 lb_n_q, lb_n_d;
  logic                 ub_n_q, ub_n_d;
  logic                 drv_q, drv_d;
  logic [SRAM_DW-1:0]   dq_out_q, dq_out_d;
  logic                 last_s;
  logic                 hi_s;
  logic                 unused_addr_s;

  assign unused_addr_s = ^i_addr[1:0];

  // Sequencer: request latching, half-access ordering and read-data capture.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    wren_d   = wren_q;
    word_d   = word_q;
    bmask_d  = bmask_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    last_s   = (phase_q == PH_LAST);
    case (state_q)
      IDLE: begin
        phase_d = PH_ZERO;
        if (i_req && ready_q) begin
          wren_d  = i_wren;
          word_d  = i_addr[18:2];
          bmask_d = i_bmask;
          wdata_d = i_wdata;
          if (!i_wren || (i_bmask[1:0] != 2'b00)) begin
            state_d = LO;
          end else if (i_bmask[3:2] != 2'b00) begin
            state_d = HI;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LO: begin
        if (last_s) begin
          phase_d = PH_ZERO;
          if (!wren_q) begin
            shadow_d[15:0] = io_sram_dq;
          end else begin
            shadow_d = shadow_q;
          end
          if (!wren_q || (bmask_q[3:2] != 2'b00)) begin
            state_d = HI;
          end else begin
            state_d = DONE;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      HI: begin
        if (last_s) begin
          phase_d = PH_ZERO;
          state_d = DONE;
          if (!wren_q) begin
            shadow_d[31:16] = io_sram_dq;
            rdata_d         = {io_sram_dq, shadow_q[15:0]};
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin values are derived from the next state so the registered pins line up with state_q.
  always_comb begin
    hi_s     = (state_d == HI);
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    drv_d    = 1'b0;
    if ((state_d == LO) || (state_d == HI)) begin
      addr_d = {word_d, hi_s};
      ce_n_d = 1'b0;
      if (wren_d) begin
        drv_d            = 1'b1;
        dq_out_d         = hi_s ? wdata_d[31:16] : wdata_d[15:0];
        {ub_n_d, lb_n_d} = lanes_n(bmask_d, hi_s);
        we_n_d           = (phase_d == PH_LAST);
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end else begin
      drv_d = 1'b0;
    end
    ready_d = (state_d == IDLE);
    ack_d   = (state_q == DONE);
  end

  // State and pin registers; reset forces the bus idle immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      phase_q  <= PH_ZERO;
      wren_q   <= 1'b0;
      word_q   <= 17'd0;
      bmask_q  <= 4'd0;
      wdata_q  <= 32'd0;
      shadow_q <= 32'd0;
      rdata_q  <= 32'd0;
      ready_q  <= 1'b0;
      ack_q    <= 1'b0;
      addr_q   <= {SRAM_AW{1'b0}};
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      drv_q    <= 1'b0;
      dq_out_q <= {SRAM_DW{1'b0}};
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      wren_q   <= wren_d;
      word_q   <= word_d;
      bmask_q  <= bmask_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
      drv_q    <= drv_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign io_sram_dq  = drv_q ? dq_out_q : {SRAM_DW{1'bz}};
  assign o_ready     = ready_q;
  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_sram_addr = addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;

endmodule
